// File: rtl/chase_controller.sv
// Chase sequencer: debounces four buttons, runs the run/pause FSM and the
// speed-programmable prescaler that drives stop/m_tick of the LED shifter.
module chase_controller #(
  parameter int BASE_TICKS   = 5_000_000,
  parameter int SPEED_LEVELS = 8,
  parameter int DEB_CYCLES   = 1_000_000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            btn_run,
  input  logic                            btn_step,
  input  logic                            btn_faster,
  input  logic                            btn_slower,
  output logic                            stop,
  output logic                            m_tick,
  output logic                            running,
  output logic [$clog2(SPEED_LEVELS)-1:0] speed
);

  localparam int SW = $clog2(SPEED_LEVELS);
  localparam int CW = $clog2(BASE_TICKS * SPEED_LEVELS);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int NB = 4;
  localparam logic [SW-1:0] SPEED_MAX = SW'(SPEED_LEVELS - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  typedef enum logic {PAUSED, RUNNING} state_t;

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] press;

  assign btn_raw = {btn_slower, btn_faster, btn_step, btn_run};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_deb
      logic          sync1_reg;
      logic          sync2_reg;
      logic          accepted_reg;
      logic          press_reg;
      logic [DW-1:0] cnt_reg;

      // Accepted level follows the synchronised input only after DEB_CYCLES
      // uninterrupted cycles of disagreement; rising acceptance is the event.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          accepted_reg <= 1'b0;
          press_reg    <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == accepted_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            accepted_reg <= sync2_reg;
            press_reg    <= sync2_reg;
            cnt_reg      <= '0;
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  // Terminal count per speed level, fixed at elaboration.
  logic [CW-1:0] term_lut [SPEED_LEVELS];

  generate
    for (gi = 0; gi < SPEED_LEVELS; gi++) begin : g_lut
      assign term_lut[gi] = CW'(BASE_TICKS * (SPEED_LEVELS - gi) - 1);
    end
  endgenerate

  state_t        state_reg;
  logic [SW-1:0] speed_reg;
  logic [CW-1:0] count_reg;
  logic          tick_reg;
  logic          step_fire_reg;

  logic run_evt;
  logic step_evt;
  logic speed_up;
  logic speed_down;
  logic speed_chg;
  logic terminal;

  assign run_evt    = press[0];
  assign step_evt   = press[1];
  assign speed_up   = press[2] & ~press[3] & (speed_reg != SPEED_MAX);
  assign speed_down = press[3] & ~press[2] & (speed_reg != '0);
  assign speed_chg  = speed_up | speed_down;
  assign terminal   = (count_reg == term_lut[speed_reg]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= PAUSED;
      speed_reg     <= '0;
      count_reg     <= '0;
      tick_reg      <= 1'b0;
      step_fire_reg <= 1'b0;
    end else begin
      tick_reg      <= 1'b0;
      step_fire_reg <= 1'b0;

      if (run_evt) begin
        state_reg <= (state_reg == PAUSED) ? RUNNING : PAUSED;
      end else if (step_evt && state_reg == PAUSED) begin
        step_fire_reg <= 1'b1;
      end

      if (speed_up) begin
        speed_reg <= speed_reg + SW'(1);
      end else if (speed_down) begin
        speed_reg <= speed_reg - SW'(1);
      end

      // A terminal count reached while leaving RUNNING still emits its tick.
      if (state_reg == PAUSED || speed_chg) begin
        count_reg <= '0;
      end else if (terminal) begin
        count_reg <= '0;
        tick_reg  <= 1'b1;
      end else begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

  assign running = (state_reg == RUNNING);
  assign stop    = (state_reg == PAUSED) & ~step_fire_reg;
  assign m_tick  = tick_reg | step_fire_reg;
  assign speed   = speed_reg;

endmodule

// File: tb/tb_chase_controller.sv
// Scoreboard bench for chase_controller with small timing parameters
// (BASE_TICKS=4, SPEED_LEVELS=4, DEB_CYCLES=3).
module tb_chase_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_faster = 1'b0;
  logic       btn_slower = 1'b0;
  logic       stop;
  logic       m_tick;
  logic       running;
  logic [1:0] speed;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit press_busy = 1'b0;
  int exp_q[$];
  int per_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chase_controller #(
    .BASE_TICKS  (4),
    .SPEED_LEVELS(4),
    .DEB_CYCLES  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_run   (btn_run),
    .btn_step  (btn_step),
    .btn_faster(btn_faster),
    .btn_slower(btn_slower),
    .stop      (stop),
    .m_tick    (m_tick),
    .running   (running),
    .speed     (speed)
  );

  task automatic check_val(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end else begin
      $display("ok   %s: %0d", tag, actual);
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: btn_run = v;
      1: btn_step = v;
      2: btn_faster = v;
      default: btn_slower = v;
    endcase
  endtask

  task automatic press(input int idx);
    press_busy = 1'b1;
    set_btn(idx, 1'b1);
    repeat (10) @(negedge clk);
    set_btn(idx, 1'b0);
    repeat (10) @(negedge clk);
    press_busy = 1'b0;
  endtask

  task automatic settle();
    while (press_busy) @(negedge clk);
  endtask

  task automatic wait_tick(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_tick) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      check_val({tag, "_timeout"}, 0, 1);
      at = cyc;
    end
  endtask

  task automatic measure_period(input string tag, output int p);
    int a, b;
    wait_tick(tag, a);
    wait_tick(tag, b);
    p = b - a;
  endtask

  // Press run and wait (bounded) for the running flag to reach the expectation.
  task automatic toggle_run(input string tag, input int exp_running, output int at);
    exp_q.push_back(exp_running);
    fork
      press(0);
    join_none
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (int'(running) == exp_running) break;
    end
    at = cyc;
    check_val(tag, int'(running), exp_q.pop_front());
  endtask

  task automatic speed_press(input int idx, input int exp_speed, input int exp_period);
    int p;
    exp_q.push_back(exp_speed);
    per_q.push_back(exp_period);
    press(idx);
    check_val($sformatf("speed_after_btn%0d", idx), int'(speed), exp_q.pop_front());
    measure_period("period", p);
    check_val($sformatf("period_at_speed%0d", exp_speed), p, per_q.pop_front());
  endtask

  initial begin
    int bad_tick, bad_stop, bad_run, bad_speed;
    int t_run, t_tick, p, nt, ns, nsl;

    // 1: reset and idle
    repeat (5) @(negedge clk);
    check_val("rst_stop", int'(stop), 1);
    check_val("rst_m_tick", int'(m_tick), 0);
    check_val("rst_running", int'(running), 0);
    check_val("rst_speed", int'(speed), 0);
    reset = 1'b1;
    bad_tick = 0; bad_stop = 0; bad_run = 0; bad_speed = 0;
    repeat (200) begin
      @(negedge clk);
      if (m_tick !== 1'b0) bad_tick++;
      if (stop !== 1'b1) bad_stop++;
      if (running !== 1'b0) bad_run++;
      if (speed !== 2'd0) bad_speed++;
    end
    check_val("idle_ticks", bad_tick, 0);
    check_val("idle_stop_low", bad_stop, 0);
    check_val("idle_running", bad_run, 0);
    check_val("idle_speed", bad_speed, 0);

    // 2: run, first tick and period at speed 0
    toggle_run("run_start", 1, t_run);
    check_val("run_stop", int'(stop), 0);
    wait_tick("first_tick", t_tick);
    check_val("first_tick_delay", t_tick - t_run, 16);
    settle();
    measure_period("p0", p);
    check_val("period_at_speed0", p, 16);

    // 3: speed up with saturation, then down with saturation
    speed_press(2, 1, 12);
    speed_press(2, 2, 8);
    speed_press(2, 3, 4);
    speed_press(2, 3, 4);
    speed_press(2, 3, 4);
    speed_press(3, 2, 8);
    speed_press(3, 1, 12);
    speed_press(3, 0, 16);
    speed_press(3, 0, 16);

    // 4: single step while paused, ignored step while running
    toggle_run("pause", 0, t_run);
    settle();
    repeat (20) @(negedge clk);
    nt = 0; ns = 0; nsl = 0;
    fork
      press(1);
    join_none
    repeat (40) begin
      @(negedge clk);
      if (m_tick) nt++;
      if (m_tick && !stop) ns++;
      if (!stop) nsl++;
    end
    check_val("step_ticks", nt, 1);
    check_val("step_tick_with_stop0", ns, 1);
    check_val("step_stop_low_cycles", nsl, 1);
    check_val("step_still_paused", int'(running), 0);
    toggle_run("resume", 1, t_run);
    settle();
    wait_tick("resync", t_tick);
    fork
      press(1);
    join_none
    for (int k = 0; k < 3; k++) begin
      int a;
      wait_tick("run_step", a);
      check_val($sformatf("run_step_gap%0d", k), a - t_tick, 16);
      t_tick = a;
    end
    settle();

    // 5: glitches and bounce on run must not toggle
    btn_run = 1'b1; repeat (2) @(negedge clk);
    btn_run = 1'b0; repeat (2) @(negedge clk);
    btn_run = 1'b1; @(negedge clk);
    btn_run = 1'b0; @(negedge clk);
    btn_run = 1'b1; @(negedge clk);
    btn_run = 1'b0;
    repeat (20) @(negedge clk);
    check_val("glitch_running", int'(running), 1);
    toggle_run("clean_toggle", 0, t_run);
    settle();

    // 6: async reset mid-count at speed 2
    toggle_run("run_again", 1, t_run);
    settle();
    speed_press(2, 1, 12);
    speed_press(2, 2, 8);
    wait_tick("pre_reset", t_tick);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("mid_rst_stop", int'(stop), 1);
    check_val("mid_rst_running", int'(running), 0);
    check_val("mid_rst_speed", int'(speed), 0);
    check_val("mid_rst_m_tick", int'(m_tick), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bad_tick = 0; bad_stop = 0;
    repeat (50) begin
      @(negedge clk);
      if (m_tick !== 1'b0) bad_tick++;
      if (stop !== 1'b1) bad_stop++;
    end
    check_val("post_rst_ticks", bad_tick, 0);
    check_val("post_rst_stop_low", bad_stop, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
